// File: rtl/shape_raster_ctrl.sv
// Raster controller: turns one shape instruction into a stream of
// pixel coordinates (bounding-box fill or corner points).
module shape_raster_ctrl #(
  parameter int WIDTH  = 4,
  parameter int HEIGHT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              shape,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  x1,
  input  logic [WIDTH-1:0]  x2,
  input  logic [WIDTH-1:0]  x3,
  input  logic [HEIGHT-1:0] y1,
  input  logic [HEIGHT-1:0] y2,
  input  logic [HEIGHT-1:0] y3,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [WIDTH-1:0]  pix_x,
  output logic [HEIGHT-1:0] pix_y,
  output logic              busy,
  output logic              done
);

  localparam int EW = WIDTH + HEIGHT + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SCAN,
    S_VERT,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic                     sq_q;
  logic [WIDTH-1:0]         vx_q [3];
  logic [HEIGHT-1:0]        vy_q [3];
  logic [WIDTH-1:0]         xmin_q, xmax_q;
  logic [HEIGHT-1:0]        ymin_q, ymax_q;
  logic [WIDTH-1:0]         cx_q, cx_d;
  logic [HEIGHT-1:0]        cy_q, cy_d;
  logic [1:0]               idx_q, idx_d;
  logic signed [WIDTH:0]    dx_q [3];
  logic signed [HEIGHT:0]   dy_q [3];

  logic                     accept;
  logic                     covered;
  logic                     all_ge, all_le;
  logic [WIDTH-1:0]         xmin_c, xmax_c, x4, vert_x;
  logic [HEIGHT-1:0]        ymin_c, ymax_c, y4, vert_y;
  logic [1:0]               last_idx;
  logic signed [EW-1:0]     rx_c [3];
  logic signed [EW-1:0]     ry_c [3];
  logic signed [EW-1:0]     ddx_c [3];
  logic signed [EW-1:0]     ddy_c [3];
  logic signed [EW-1:0]     e_c [3];

  assign instr_ready = rst_n && (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign accept      = instr_valid && instr_ready;
  assign last_idx    = sq_q ? 2'd3 : 2'd2;

  // Fourth square corner closes the parallelogram 1-2-3.
  assign x4 = vx_q[0] + vx_q[2] - vx_q[1];
  assign y4 = vy_q[0] + vy_q[2] - vy_q[1];

  always_comb begin
    xmin_c = vx_q[0];
    xmax_c = vx_q[0];
    ymin_c = vy_q[0];
    ymax_c = vy_q[0];
    for (int i = 1; i < 3; i++) begin
      if (vx_q[i] < xmin_c) xmin_c = vx_q[i];
      if (vx_q[i] > xmax_c) xmax_c = vx_q[i];
      if (vy_q[i] < ymin_c) ymin_c = vy_q[i];
      if (vy_q[i] > ymax_c) ymax_c = vy_q[i];
    end
  end

  // Edge functions; EW bits hold the worst-case product difference.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      rx_c[i]  = EW'({1'b0, cx_q}) - EW'({1'b0, vx_q[i]});
      ry_c[i]  = EW'({1'b0, cy_q}) - EW'({1'b0, vy_q[i]});
      ddx_c[i] = {{(EW-WIDTH-1){dx_q[i][WIDTH]}}, dx_q[i]};
      ddy_c[i] = {{(EW-HEIGHT-1){dy_q[i][HEIGHT]}}, dy_q[i]};
      e_c[i]   = ddx_c[i] * ry_c[i] - ddy_c[i] * rx_c[i];
    end
  end

  always_comb begin
    all_ge = 1'b1;
    all_le = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (e_c[i][EW-1]) all_ge = 1'b0;
      if (!e_c[i][EW-1] && (e_c[i] != '0)) all_le = 1'b0;
    end
    covered = sq_q || all_ge || all_le;
  end

  always_comb begin
    vert_x = x4;
    vert_y = y4;
    case (idx_q)
      2'd0: begin vert_x = vx_q[0]; vert_y = vy_q[0]; end
      2'd1: begin vert_x = vx_q[1]; vert_y = vy_q[1]; end
      2'd2: begin vert_x = vx_q[2]; vert_y = vy_q[2]; end
      default: ;
    endcase
  end

  assign pix_x = (state_q == S_VERT) ? vert_x : cx_q;
  assign pix_y = (state_q == S_VERT) ? vert_y : cy_q;

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    idx_d     = idx_q;
    pix_valid = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            (op == 2'b01): state_d = S_SETUP;
            (op == 2'b10): begin
              state_d = S_VERT;
              idx_d   = 2'd0;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_SETUP: begin
        cx_d    = xmin_c;
        cy_d    = ymin_c;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        pix_valid = covered;
        if (!covered || pix_ready) begin
          if (cx_q == xmax_q) begin
            cx_d = xmin_q;
            if (cy_q == ymax_q) state_d = S_DONE;
            else cy_d = cy_q + 1'b1;
          end else begin
            cx_d = cx_q + 1'b1;
          end
        end
      end
      S_VERT: begin
        pix_valid = 1'b1;
        if (pix_ready) begin
          if (idx_q == last_idx) state_d = S_DONE;
          else idx_d = idx_q + 2'd1;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q   <= 1'b0;
      xmin_q <= '0;
      xmax_q <= '0;
      ymin_q <= '0;
      ymax_q <= '0;
      for (int i = 0; i < 3; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
        dx_q[i] <= '0;
        dy_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        sq_q    <= shape;
        vx_q[0] <= x1;
        vx_q[1] <= x2;
        vx_q[2] <= x3;
        vy_q[0] <= y1;
        vy_q[1] <= y2;
        vy_q[2] <= y3;
      end
      if (state_q == S_SETUP) begin
        xmin_q <= xmin_c;
        xmax_q <= xmax_c;
        ymin_q <= ymin_c;
        ymax_q <= ymax_c;
        for (int i = 0; i < 3; i++) begin
          dx_q[i] <= $signed({1'b0, vx_q[(i+1)%3]})
                   - $signed({1'b0, vx_q[i]});
          dy_q[i] <= $signed({1'b0, vy_q[(i+1)%3]})
                   - $signed({1'b0, vy_q[i]});
        end
      end
    end
  end

endmodule

// File: tb/tb_shape_raster_ctrl.sv
// Randomized bench for shape_raster_ctrl with a box/edge-function
// reference model and per-scenario checks.
module tb_shape_raster_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       shape = 1'b0;
  logic [1:0] op = 2'b00;
  logic [3:0] x1 = '0, x2 = '0, x3 = '0;
  logic [2:0] y1 = '0, y2 = '0, y3 = '0;
  logic       pix_ready = 1'b0;
  logic       instr_ready, pix_valid, busy, done;
  logic [3:0] pix_x;
  logic [2:0] pix_y;

  always #5 clk = ~clk;

  shape_raster_ctrl #(.WIDTH(4), .HEIGHT(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .shape(shape), .op(op),
    .x1(x1), .x2(x2), .x3(x3),
    .y1(y1), .y2(y2), .y3(y3),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y),
    .busy(busy), .done(done)
  );

  int n_checks = 0;
  int n_pass = 0;

  int exp_x[$], exp_y[$];
  int got_x[$], got_y[$], got_c[$];
  int exp_base;

  int r_done_cyc, r_stalls, r_hold_err, r_valid_cyc;
  bit r_accept_ok, r_rdy_after, r_done_after, r_timeout;

  function automatic bit tri_in(int vx[3], int vy[3], int px, int py);
    bit ge = 1'b1;
    bit le = 1'b1;
    int e;
    for (int i = 0; i < 3; i++) begin
      e = (vx[(i+1)%3] - vx[i]) * (py - vy[i])
        - (vy[(i+1)%3] - vy[i]) * (px - vx[i]);
      if (e < 0) ge = 1'b0;
      if (e > 0) le = 1'b0;
    end
    return ge || le;
  endfunction

  task automatic model(input bit sh, input int o,
                       input int ax, input int bx, input int cx,
                       input int ay, input int by, input int cy);
    int vx[3];
    int vy[3];
    int xmn, xmx, ymn, ymx;
    vx = '{ax, bx, cx};
    vy = '{ay, by, cy};
    exp_x.delete();
    exp_y.delete();
    if (o == 1) begin
      xmn = vx[0]; xmx = vx[0]; ymn = vy[0]; ymx = vy[0];
      for (int i = 1; i < 3; i++) begin
        if (vx[i] < xmn) xmn = vx[i];
        if (vx[i] > xmx) xmx = vx[i];
        if (vy[i] < ymn) ymn = vy[i];
        if (vy[i] > ymx) ymx = vy[i];
      end
      for (int y = ymn; y <= ymx; y++)
        for (int x = xmn; x <= xmx; x++)
          if (sh || tri_in(vx, vy, x, y)) begin
            exp_x.push_back(x);
            exp_y.push_back(y);
          end
      exp_base = 2 + (xmx - xmn + 1) * (ymx - ymn + 1);
    end else if (o == 2) begin
      for (int i = 0; i < 3; i++) begin
        exp_x.push_back(vx[i]);
        exp_y.push_back(vy[i]);
      end
      if (sh) begin
        exp_x.push_back((ax + cx - bx) & 15);
        exp_y.push_back((ay + cy - by) & 7);
      end
      exp_base = sh ? 5 : 4;
    end else begin
      exp_base = 1;
    end
  endtask

  function automatic int pix_diff();
    int n = 0;
    if (got_x.size() != exp_x.size()) n++;
    for (int i = 0; i < exp_x.size() && i < got_x.size(); i++)
      if (got_x[i] != exp_x[i] || got_y[i] != exp_y[i]) n++;
    return n;
  endfunction

  // Entered and left on a falling edge; cycle 0 is the accept cycle.
  task automatic run_instr(input bit sh, input int o,
                           input int ax, input int bx, input int cx,
                           input int ay, input int by, input int cy,
                           input int pct);
    int cyc;
    bit prev_stall;
    int px_prev, py_prev;
    got_x.delete(); got_y.delete(); got_c.delete();
    r_done_cyc = -1; r_stalls = 0; r_hold_err = 0; r_valid_cyc = 0;
    r_timeout = 1'b0;
    r_accept_ok = instr_ready;
    instr_valid = 1'b1;
    shape = sh;
    op = 2'(o);
    x1 = 4'(ax); x2 = 4'(bx); x3 = 4'(cx);
    y1 = 3'(ay); y2 = 3'(by); y3 = 3'(cy);
    pix_ready = ($urandom_range(99) < pct);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    cyc = 1;
    prev_stall = 1'b0;
    px_prev = 0;
    py_prev = 0;
    while (1) begin
      if (prev_stall && (pix_valid !== 1'b1 || int'(pix_x) != px_prev
                         || int'(pix_y) != py_prev))
        r_hold_err++;
      if (done === 1'b1) begin
        r_done_cyc = cyc;
        break;
      end
      if (cyc > 2000) begin
        r_timeout = 1'b1;
        break;
      end
      pix_ready = ($urandom_range(99) < pct);
      if (pix_valid === 1'b1) begin
        r_valid_cyc++;
        if (pix_ready) begin
          got_x.push_back(int'(pix_x));
          got_y.push_back(int'(pix_y));
          got_c.push_back(cyc);
        end else begin
          r_stalls++;
        end
      end
      prev_stall = (pix_valid === 1'b1) && !pix_ready;
      px_prev = int'(pix_x);
      py_prev = int'(pix_y);
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    @(negedge clk);
    r_rdy_after = instr_ready;
    r_done_after = done;
    if (r_timeout) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({pix_valid, busy, done, instr_ready} !== 4'b0000)
      $display("FAIL reset_outs: pv/busy/done/rdy=%b need 0000",
               {pix_valid, busy, done, instr_ready});
    else n_pass++;
    n_checks++;
    if (pix_x !== 4'd0 || pix_y !== 3'd0)
      $display("FAIL reset_pix: x=%0d y=%0d need 0 0", pix_x, pix_y);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (instr_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: rdy=%b busy=%b need 1 0",
               instr_ready, busy);
    else n_pass++;
  endtask

  task automatic test_square_fill();
    int first;
    model(1'b1, 1, 1, 3, 3, 1, 1, 2);
    run_instr(1'b1, 1, 1, 3, 3, 1, 1, 2, 100);
    first = got_c.size() > 0 ? got_c[0] : -1;
    n_checks++;
    if (r_accept_ok !== 1'b1 || r_timeout)
      $display("FAIL sq_accept: acc=%b to=%b need 1 0",
               r_accept_ok, r_timeout);
    else n_pass++;
    n_checks++;
    if (pix_diff() != 0)
      $display("FAIL sq_pixels: diff=%0d got %0d px need %0d px",
               pix_diff(), got_x.size(), exp_x.size());
    else n_pass++;
    n_checks++;
    if (first != 2)
      $display("FAIL sq_first_cyc: got %0d need 2", first);
    else n_pass++;
    n_checks++;
    if (r_done_cyc != 8)
      $display("FAIL sq_done_cyc: got %0d need 8", r_done_cyc);
    else n_pass++;
    n_checks++;
    if (r_rdy_after !== 1'b1 || r_done_after !== 1'b0)
      $display("FAIL sq_after_done: rdy=%b done=%b need 1 0",
               r_rdy_after, r_done_after);
    else n_pass++;
  endtask

  task automatic test_tri_fill();
    model(1'b0, 1, 0, 2, 0, 0, 0, 2);
    run_instr(1'b0, 1, 0, 2, 0, 0, 0, 2, 100);
    n_checks++;
    if (pix_diff() != 0 || got_x.size() != 6)
      $display("FAIL tri_pixels: diff=%0d got %0d px need 6 px",
               pix_diff(), got_x.size());
    else n_pass++;
    n_checks++;
    if (r_done_cyc != 11)
      $display("FAIL tri_done_cyc: got %0d need 11", r_done_cyc);
    else n_pass++;
    n_checks++;
    if (r_valid_cyc != 6)
      $display("FAIL tri_valid_cycles: got %0d need 6", r_valid_cyc);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    model(1'b1, 1, 0, 1, 1, 0, 0, 1);
    run_instr(1'b1, 1, 0, 1, 1, 0, 0, 1, 50);
    n_checks++;
    if (pix_diff() != 0)
      $display("FAIL bp_pixels: diff=%0d got %0d px need %0d px",
               pix_diff(), got_x.size(), exp_x.size());
    else n_pass++;
    n_checks++;
    if (r_hold_err != 0)
      $display("FAIL bp_hold: %0d unstable stalls need 0", r_hold_err);
    else n_pass++;
    n_checks++;
    if (r_done_cyc != 6 + r_stalls)
      $display("FAIL bp_done_cyc: got %0d need %0d",
               r_done_cyc, 6 + r_stalls);
    else n_pass++;
  endtask

  task automatic test_verts();
    int lx, ly;
    model(1'b1, 2, 1, 4, 4, 1, 1, 3);
    run_instr(1'b1, 2, 1, 4, 4, 1, 1, 3, 100);
    n_checks++;
    if (pix_diff() != 0)
      $display("FAIL verts_sq: diff=%0d got %0d px need %0d px",
               pix_diff(), got_x.size(), exp_x.size());
    else n_pass++;
    n_checks++;
    if (r_done_cyc != 5)
      $display("FAIL verts_done_cyc: got %0d need 5", r_done_cyc);
    else n_pass++;
    run_instr(1'b1, 2, 0, 15, 0, 0, 0, 7, 100);
    lx = got_x.size() == 4 ? got_x[3] : -1;
    ly = got_y.size() == 4 ? got_y[3] : -1;
    n_checks++;
    if (lx != 1 || ly != 7)
      $display("FAIL verts_wrap: got (%0d,%0d) need (1,7)", lx, ly);
    else n_pass++;
  endtask

  task automatic test_nop();
    for (int k = 0; k < 2; k++) begin
      run_instr(1'b0, k == 0 ? 0 : 3, 1, 2, 3, 1, 2, 3, 100);
      n_checks++;
      if (r_done_cyc != 1 || got_x.size() != 0 || r_valid_cyc != 0)
        $display("FAIL nop_%0d: done_cyc=%0d px=%0d need 1 0",
                 k, r_done_cyc, r_valid_cyc);
      else n_pass++;
      n_checks++;
      if (r_rdy_after !== 1'b1)
        $display("FAIL nop_ready_%0d: got %b need 1", k, r_rdy_after);
      else n_pass++;
    end
    model(1'b1, 1, 2, 2, 2, 5, 5, 5);
    run_instr(1'b1, 1, 2, 2, 2, 5, 5, 5, 100);
    n_checks++;
    if (r_accept_ok !== 1'b1 || pix_diff() != 0 || r_done_cyc != 3)
      $display("FAIL nop_then_fill: acc=%b diff=%0d done=%0d need 1 0 3",
               r_accept_ok, pix_diff(), r_done_cyc);
    else n_pass++;
  endtask

  task automatic test_random();
    int o, pct, ax, bx, cx, ay, by, cy;
    bit sh;
    for (int it = 0; it < 25; it++) begin
      o = $urandom_range(0, 9) < 5 ? 1 : 2;
      if ($urandom_range(0, 9) == 0) o = $urandom_range(0, 1) ? 0 : 3;
      sh = 1'($urandom_range(0, 1));
      ax = $urandom_range(0, 15); bx = $urandom_range(0, 15);
      cx = $urandom_range(0, 15);
      ay = $urandom_range(0, 7); by = $urandom_range(0, 7);
      cy = $urandom_range(0, 7);
      if (it % 5 == 0) begin bx = ax + 1 > 15 ? ax : ax + 1; by = ay; end
      pct = (it % 3 == 0) ? 100 : $urandom_range(30, 90);
      model(sh, o, ax, bx, cx, ay, by, cy);
      run_instr(sh, o, ax, bx, cx, ay, by, cy, pct);
      n_checks++;
      if (pix_diff() != 0 || r_hold_err != 0 || r_timeout)
        $display("FAIL rand_%0d: diff=%0d hold=%0d to=%b need 0 0 0",
                 it, pix_diff(), r_hold_err, r_timeout);
      else n_pass++;
      n_checks++;
      if (r_done_cyc != exp_base + r_stalls)
        $display("FAIL rand_done_%0d: got %0d need %0d",
                 it, r_done_cyc, exp_base + r_stalls);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_scan();
    bit seen_done = 1'b0;
    instr_valid = 1'b1;
    shape = 1'b1;
    op = 2'b01;
    x1 = 4'd0; x2 = 4'd15; x3 = 4'd15;
    y1 = 3'd0; y2 = 3'd0; y3 = 3'd7;
    pix_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (pix_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL mid_scan_active: pv=%b busy=%b need 1 1",
               pix_valid, busy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pix_valid, busy, done, instr_ready} !== 4'b0000)
      $display("FAIL mid_reset_outs: pv/busy/done/rdy=%b need 0000",
               {pix_valid, busy, done, instr_ready});
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (done === 1'b1) seen_done = 1'b1;
    n_checks++;
    if (seen_done || instr_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL mid_reset_idle: done_seen=%b rdy=%b busy=%b need 0 1 0",
               seen_done, instr_ready, busy);
    else n_pass++;
    model(1'b0, 1, 3, 5, 3, 1, 1, 3);
    run_instr(1'b0, 1, 3, 5, 3, 1, 1, 3, 100);
    n_checks++;
    if (pix_diff() != 0 || r_done_cyc != exp_base)
      $display("FAIL mid_reset_refill: diff=%0d done=%0d need 0 %0d",
               pix_diff(), r_done_cyc, exp_base);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_square_fill();
    test_tri_fill();
    test_backpressure();
    test_verts();
    test_nop();
    test_random();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
